fft_cadd_pipe: RTL

- Parametrised, pipelined complex adder/subtractor for the FFT datapath.
- Computes A+B or A−B on signed real/imag pairs, with optional divide-by-2 rounding scaling per transaction.
- Configurable pipeline depth with valid/ready backpressure and a sticky overflow flag.
- Sits between butterfly multipliers and stage memories; it is the next generation of the plain registered complex adder.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_cadd_core.sv | 36 +++
 rtl/fft_cadd_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the widened add/sub/scale/overflow helpers.
// Helpers work on a fixed CADD_XW-bit signed word, so operand widths up to 64 bits are supported.
package fft_pkg;

  localparam logic CADD_MODE_ADD = 1'b0;
  localparam logic CADD_MODE_SUB = 1'b1;

  localparam int CADD_XW = 66;

  function automatic logic signed [CADD_XW-1:0] cadd_calc(
    input logic signed [CADD_XW-1:0] a,
    input logic signed [CADD_XW-1:0] b,
    input logic                      mode,
    input logic                      scale
  );
    logic signed [CADD_XW-1:0] s;
    logic signed [CADD_XW-1:0] t;
    s = (mode == CADD_MODE_SUB) ? (a - b) : (a + b);
    // Adding one before the arithmetic shift rounds half up, including for negatives.
    t = s + CADD_XW'(1);
    return scale ? (t >>> 1) : s;
  endfunction

  function automatic logic cadd_ovf(
    input logic signed [CADD_XW-1:0] r,
    input int                        w
  );
    logic signed [CADD_XW-1:0] hi;
    logic signed [CADD_XW-1:0] lo;
    hi = (CADD_XW'(1) <<< (w - 1)) - CADD_XW'(1);
    lo = -hi - CADD_XW'(1);
    return (r > hi) || (r < lo);
  endfunction

endpackage

// File: rtl/fft_cadd_core.sv
// One component (real or imag) of the complex add/sub: compute, scale, overflow detect.
// FFT_CADD_SAT_EN selects saturation on overflow; otherwise the result wraps.
module fft_cadd_core
  import fft_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    mode,
  input  logic                    scale,
  output logic        [WIDTH-1:0] res,
  output logic                    ovf
);

  logic signed [CADD_XW-1:0] ax;
  logic signed [CADD_XW-1:0] bx;
  logic signed [CADD_XW-1:0] r;

  assign ax  = {{(CADD_XW-WIDTH){a[WIDTH-1]}}, a};
  assign bx  = {{(CADD_XW-WIDTH){b[WIDTH-1]}}, b};
  assign r   = cadd_calc(ax, bx, mode, scale);
  assign ovf = cadd_ovf(r, WIDTH);

`ifdef FFT_CADD_SAT_EN
  always_comb begin
    res = r[WIDTH-1:0];
    if (ovf) begin
      res = r[CADD_XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res = r[WIDTH-1:0];
`endif

endmodule

// File: rtl/fft_cadd_pipe.sv
// Pipelined complex adder/subtractor with global-stall valid/ready and sticky overflow.
// Optional saturation via FFT_CADD_SAT_EN (see fft_cadd_core).
module fft_cadd_pipe
  import fft_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic                    scale,
  input  logic signed [WIDTH-1:0] real_a,
  input  logic signed [WIDTH-1:0] imag_a,
  input  logic signed [WIDTH-1:0] real_b,
  input  logic signed [WIDTH-1:0] imag_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [WIDTH-1:0] real_out,
  output logic        [WIDTH-1:0] imag_out,
  output logic                    ovf_sticky,
  input  logic                    clr_ovf
);

  logic [WIDTH-1:0]  re_c;
  logic [WIDTH-1:0]  im_c;
  logic              ovf_re;
  logic              ovf_im;
  logic              stall;
  logic              accept;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  re_q [STAGES];
  logic [WIDTH-1:0]  im_q [STAGES];

  fft_cadd_core #(.WIDTH(WIDTH)) u_core_re (
    .a(real_a), .b(real_b), .mode(mode), .scale(scale), .res(re_c), .ovf(ovf_re)
  );

  fft_cadd_core #(.WIDTH(WIDTH)) u_core_im (
    .a(imag_a), .b(imag_b), .mode(mode), .scale(scale), .res(im_c), .ovf(ovf_im)
  );

  assign stall    = vld[STAGES-1] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & ~stall;

  // Global stall: every stage freezes together, bubbles are carried, not squeezed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (!stall) begin
      vld[0] <= in_valid;
      if (in_valid) begin
        re_q[0] <= re_c;
        im_q[0] <= im_c;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          re_q[i] <= re_q[i-1];
          im_q[i] <= im_q[i-1];
        end
      end
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (accept && (ovf_re || ovf_im)) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign real_out  = re_q[STAGES-1];
  assign imag_out  = im_q[STAGES-1];

endmodule
